// File: rtl/contador_bcd.sv
// contador_bcd: four-digit BCD up/down counter with load, plus a free-running
// digit scan that time-multiplexes the digits onto one 4-bit bus for a
// shared 7-segment encoder.
module contador_bcd #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] din,
  output logic [15:0] valor,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        carry
);

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NDIG-1:0][DIG_W-1:0] dig_q, dig_d;
  logic                       carry_q, carry_d;
  logic [1:0]                 idx_q, idx_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic                       rip;

  // Next digit values: load (nibbles above 9 forced to 0) beats a ripple step.
  always_comb begin
    dig_d   = dig_q;
    carry_d = 1'b0;
    rip     = 1'b0;
    if (load) begin
      for (int i = 0; i < NDIG; i++) begin
        dig_d[i] = (din[i*DIG_W +: DIG_W] > 4'd9) ? 4'd0 : din[i*DIG_W +: DIG_W];
      end
    end else if (en) begin
      rip = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        if (rip) begin
          if (up) begin
            if (dig_q[i] == 4'd9) begin
              dig_d[i] = 4'd0;
            end else begin
              dig_d[i] = dig_q[i] + 4'd1;
              rip      = 1'b0;
            end
          end else begin
            if (dig_q[i] == 4'd0) begin
              dig_d[i] = 4'd9;
            end else begin
              dig_d[i] = dig_q[i] - 4'd1;
              rip      = 1'b0;
            end
          end
        end
      end
      // A ripple out of the thousands digit means 9999<->0000 wrapped.
      carry_d = rip;
    end
  end

  // Scan divider: dwell SCAN_DIV cycles per digit, then advance the index.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= 2'd0;
      div_q   <= '0;
    end else begin
      dig_q   <= dig_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
    end
  end

  assign valor = dig_q;
  assign carry = carry_q;
  assign an    = 4'b0001 << idx_q;
  assign bcd   = dig_q[idx_q];

endmodule

// File: tb/tb_contador_bcd.sv
// Scoreboard bench for contador_bcd: the driver pushes the expected count and
// carry per edge, a monitor pops and compares, and checks the scan outputs
// against a cycle-count model of the display scan.
module tb_contador_bcd;

  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up = 1'b0, load = 1'b0;
  logic [15:0] din = 16'h0;
  logic [15:0] valor;
  logic [3:0]  bcd, an;
  logic        carry;

  typedef struct {
    logic [15:0] v;
    logic        c;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt = 0;       // model count as a plain integer 0..9999
  logic        m_car = 1'b0;
  logic [15:0] cur_v = 16'h0;   // expected valor currently on the outputs
  int          ncyc = 0;        // clock edges since reset was released

  contador_bcd #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .valor(valor), .bcd(bcd), .an(an), .carry(carry)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs (called at a falling edge) and record the outcome.
  task automatic step(input logic l, input logic e, input logic u, input logic [15:0] d);
    int nib;
    load = l; en = e; up = u; din = d;
    if (l) begin
      m_cnt = 0;
      for (int i = 3; i >= 0; i--) begin
        nib   = int'(d[i*4 +: 4]);
        m_cnt = m_cnt * 10 + ((nib > 9) ? 0 : nib);
      end
      m_car = 1'b0;
    end else if (e) begin
      if (u) begin
        m_car = (m_cnt == 9999);
        m_cnt = (m_cnt == 9999) ? 0 : m_cnt + 1;
      end else begin
        m_car = (m_cnt == 0);
        m_cnt = (m_cnt == 0) ? 9999 : m_cnt - 1;
      end
    end else begin
      m_car = 1'b0;
    end
    q.push_back('{to_bcd(m_cnt), m_car});
    @(negedge clk);
  endtask

  // Assert reset between edges, check it acts at once, release on a falling edge.
  task automatic do_reset();
    #2;
    rst = 1'b1; load = 1'b0; en = 1'b0;
    q.delete();
    m_cnt = 0; m_car = 1'b0; cur_v = 16'h0;
    #1;
    chk("rst_valor", valor, 16'h0000);
    chk("rst_an", {12'h0, an}, 16'h0001);
    chk("rst_bcd", {12'h0, bcd}, 16'h0000);
    chk("rst_carry", {15'h0, carry}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: after each edge pop the expected count and check scan outputs.
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(posedge clk);
      if (rst) begin
        ncyc = 0;
      end else begin
        ncyc++;
        #2;
        if (q.size() > 0) begin
          e     = q.pop_front();
          cur_v = e.v;
          chk("valor", valor, e.v);
          chk("carry", {15'h0, carry}, {15'h0, e.c});
        end
        idx = (ncyc / int'(SD)) % 4;
        chk("an", {12'h0, an}, 16'(1 << idx));
        chk("bcd", {12'h0, bcd}, {12'h0, cur_v[idx*4 +: 4]});
      end
    end
  end

  initial begin
    logic [15:0] rd;
    repeat (2) @(negedge clk);
    do_reset();

    // Full scan frame and a bit more from reset, holding.
    for (int i = 0; i < 4 * SD + 2; i++) step(0, 0, $urandom_range(0, 1), 16'h0);

    // Up ripple.
    step(1, 0, 0, 16'h0199);
    step(0, 1, 1, 16'h0);
    step(0, 1, 1, 16'h0);
    // Up wrap.
    step(1, 0, 0, 16'h9998);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'h0);
    // Down wrap and borrow.
    step(1, 0, 1, 16'h0001);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h1000);
    step(0, 1, 0, 16'h0);
    // Load beats enable; invalid nibbles zeroed; hold through a full frame.
    step(1, 0, 1, 16'h9999);
    step(0, 1, 1, 16'h0);
    step(1, 1, 1, 16'h3A7F);
    for (int i = 0; i < 4 * SD; i++) step(0, 0, $urandom_range(0, 1), 16'h0);

    // Reset mid-count while the thousands digit is scanned.
    step(1, 0, 0, 16'h4566);
    step(0, 1, 1, 16'h0);
    for (int i = 0; i < 4 * SD && ((ncyc / int'(SD)) % 4) != 3; i++) step(0, 0, 0, 16'h0);
    do_reset();
    step(0, 1, 1, 16'h0);
    step(0, 1, 1, 16'h0);

    // Randomised traffic, with occasional loads near the wrap points.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 15))
        0:       rd = $urandom();
        1:       rd = 16'h9998;
        2:       rd = 16'h0001;
        default: rd = 16'h0;
      endcase
      step((rd != 16'h0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1), rd);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/contador_bcd.md
# contador_bcd

Four-digit synchronous BCD up/down counter with built-in display scan, sitting directly upstream of the BCD-to-7-segment encoder. It holds a 0000–9999 decimal count and supports load, enable and direction. It time-multiplexes the four digits onto a single 4-bit `bcd` bus, with a one-hot digit select, so one shared encoder can drive a multiplexed 4-digit display.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit stays selected; legal range 1..65535.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: count enable; one step per clock while high.
- `up`  in  1: direction; 1 = increment, 0 = decrement; sampled only when a step occurs.
- `load`  in  1: synchronous load of `din`; has priority over `en`.
- `din`  in  16: four BCD digits, [15:12] = thousands … [3:0] = units.
- `valor`  out  16: current count, same packing as `din`.
- `bcd`  out  4: digit currently scanned; feeds the encoder.
- `an`  out  4: one-hot digit select, active-high; bit i selects digit i (0 = units).
- `carry`  out  1: one-cycle wrap flag.

## Operation
- State:
  - Four 4-bit digit registers.
  - 2-bit scan index `idx`.
  - Scan divider `div`, width ceil(log2(SCAN_DIV)), minimum 1 bit.
  - Registered `carry`.
- Reset (asynchronous, immediate, including mid-count or mid-scan): `valor` = 0000, `idx` = 0, `div` = 0, `an` = 0001, `bcd` = 0000, `carry` = 0.
- Priority per edge: `load` > `en` > hold.
- Load:
  - Each `din` nibble is written to its digit.
  - Any nibble greater than 9 (A–F) is written as 0; other nibbles are unaffected.
  - `carry` is cleared on a load edge.
- Increment (`en`=1, `up`=1):
  - Units +1. A digit at 9 becomes 0 and propagates +1 to the next digit (ripple within the same cycle).
  - 9999 → 0000 sets `carry`=1.
- Decrement (`en`=1, `up`=0):
  - Units −1. A digit at 0 becomes 9 and propagates a borrow.
  - 0000 → 9999 sets `carry`=1.
- Hold (`en`=0, `load`=0): digits unchanged. Any non-wrapping edge, including hold, clears `carry`, so `carry` is never high for two consecutive cycles.
- Digits never hold values outside 0–9.
- Scan:
  - Runs continuously, independent of `en` and `load`.
  - `div` counts 0..SCAN_DIV−1. On the edge where `div` = SCAN_DIV−1, `div` returns to 0 and `idx` advances 0→1→2→3→0.
  - With SCAN_DIV = 1, `idx` advances every cycle.
- Outputs: `an` = 1 << `idx`; `bcd` = digit[`idx`]. Both are decoded directly from registers, with no extra pipeline stage.

## Timing
- Load or count latency: the new value is visible on `valor` immediately after the active edge (1 cycle).
- `bcd` tracks a count change on the same edge if the changed digit is currently selected.
- `carry` is high for exactly the cycle following the wrapping edge.
- Digit dwell is exactly SCAN_DIV cycles; a full scan frame is 4·SCAN_DIV cycles.
- `an` always has exactly one bit set, including during and after reset.
- `load` and `en` high together: load wins, no step is taken and `carry` = 0.
- `up` toggling while `en`=0 has no effect.

## Test plan
- Reset and scan: assert `rst` asynchronously between edges, then release. Required: immediately `valor`=0000, `an`=0001, `carry`=0. With SCAN_DIV=4, `an` is 0001 for cycles 0–3, 0010 for 4–7, 0100 for 8–11, 1000 for 12–15, then 0001.
- Up-count ripple: load 0x0199, then `en`=1, `up`=1 for 2 cycles. Required: `valor` 0200 then 0201; `carry` stays 0.
- Up wrap: load 0x9998, then `en`=1, `up`=1 for 3 cycles. Required: 9999, 0000 with `carry`=1, 0001 with `carry`=0.
- Down wrap and borrow: load 0x0001, then `en`=1, `up`=0 for 3 cycles. Required: 0000, 9999 with `carry`=1, 9998 with `carry`=0. Separately, load 0x1000 and step down once. Required: 0999.
- Load priority and sanitising: `load`=1, `en`=1, `din`=0x3A7F. Required: `valor`=3070, no step, `carry`=0. When `idx`=2 is scanned, `bcd`=0, `an`=0100.
- Reset mid-operation: assert `rst` while counting at 4567 with `idx`=3. Required: `valor`=0000, `an`=0001, `bcd`=0000 immediately. Counting resumes from 0001 on the first enabled edge after release.
